lfsr_checker: RTL
=================

Name: lfsr_checker

Overview:
- Receive side of the 128-bit LFSR pattern path. It accepts one 128-bit word per valid cycle from the LFSR generator output, or from a link that carries it.
- Self-synchronises to the pattern by seeding a local reference LFSR from the received data. After lock it checks every following word against the locally predicted word.
- Reports lock state and saturating word-error and bit-error counters. These are intended for ILA/VIO probing on hardware.

Parameters:
- WIDTH, 128, LFSR / data word width.
- LOCK_COUNT, 4, consecutive matching words needed in SEARCH before declaring lock.
- UNLOCK_COUNT, 8, consecutive mismatching words in LOCKED before dropping to SEARCH.
- CNT_W, 32, width of every counter output.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_valid  in  1  data_in carries one new LFSR step this cycle.
- data_in  in  WIDTH  received LFSR word.
- clear_counts  in  1  synchronous clear of all counters; lock state is kept.
- locked  out  1  checker is synchronised to the pattern.
- err_flag  out  1  one-cycle pulse: the last checked word mismatched while LOCKED.
- word_count  out  CNT_W  words checked while LOCKED.
- word_err_count  out  CNT_W  mismatching words while LOCKED.
- bit_err_count  out  CNT_W  total mismatching bits while LOCKED.

Behaviour:
- Polynomial (fixed, identical to the generator):
  - x^128 + x^126 + x^101 + x^99 + 1, Fibonacci form.
  - next(s) = {s[126:0], s[127]^s[125]^s[100]^s[98]}.
  - The generator advances exactly one step per data_valid word.
- Reset (async, active-high):
  - state = SEARCH, locked = 0, err_flag = 0, all counters = 0.
  - expected register = 0, match/miss counters = 0.
- State SEARCH:
  - On a valid word with expected == 0 (no candidate yet): if data_in != 0, load expected <= next(data_in). An all-zero word is the LFSR lockup state: ignore it and leave expected at 0.
  - On a valid word with a candidate:
    - data_in == expected: match_cnt++, expected <= next(expected).
    - mismatch: match_cnt = 0, reseed expected <= next(data_in), or clear to 0 if data_in == 0.
  - When match_cnt reaches LOCK_COUNT: go to LOCKED and set locked = 1 on the cycle after the final matching word.
  - No error counting in SEARCH.
- State LOCKED:
  - Every valid word: expected <= next(expected). The reference free-runs, so the check never reseeds from data and a single corrupted word produces a single error.
  - word_count++.
  - On mismatch:
    - err_flag = 1 for one cycle.
    - word_err_count++.
    - bit_err_count += popcount(data_in ^ expected).
    - miss_cnt++.
  - On match: miss_cnt = 0.
  - When miss_cnt reaches UNLOCK_COUNT: go to SEARCH with locked = 0, expected = 0, match_cnt = 0.
- Latency:
  - Compare and all count outputs update on the clock edge after the valid word is sampled (1-cycle registered latency).
  - Cycles with data_valid = 0 change nothing, and err_flag = 0 on those cycles.
- Saturation: every counter saturates at 2^CNT_W-1. bit_err_count saturates rather than wrapping when the addition overflows.
- clear_counts:
  - Zeroes word_count, word_err_count and bit_err_count on the next edge.
  - If it coincides with a valid word, clear wins and that word is not counted. err_flag still reflects that word's compare.
  - It does not affect the state, locked, expected, match_cnt or miss_cnt.
- Reset mid-operation: async return to reset values regardless of state, and the next valid word after reset release starts SEARCH afresh.
- Popcount is 128-bit combinational and feeds the registered adder. No extra pipeline stage.

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_WIDTH = 128.
  - Tap constants 127/125/100/98.
  - A function lfsr_next(), also used by the generator so both ends share one definition.
  - State enum {SEARCH, LOCKED}.
- One natural sub-module: popcount128 (combinational bit-count of a WIDTH-bit vector, output width 8).

Test Plan:
- Lock from seed 1:
  - Stimulus: feed 128'h1, 128'h2, 128'h4, 128'h8, 128'h10, valid every cycle.
  - Required: locked rises the cycle after 128'h10 (4 matches); all counters 0; err_flag never set.
- Single-bit error:
  - Stimulus: when locked, send the correct word with bit 5 flipped, then continue the correct sequence.
  - Required: err_flag pulses once; word_err_count = 1; bit_err_count = 1; locked stays 1; the following words match.
- Loss of lock:
  - Stimulus: when locked, send 8 consecutive 128'hFFFF...F words.
  - Required: locked = 0 after the 8th word; word_err_count = 8; bit_err_count equals the sum of popcounts of each word XOR its expected value.
- Zero-seed and gaps:
  - Stimulus: feed 128'h0 words, then a valid sequence with data_valid toggling 1/0.
  - Required: zeros are ignored; lock is reached after LOCK_COUNT valid matches; idle cycles change nothing.
- Clear and saturation:
  - Stimulus: pulse clear_counts together with an erroneous word. Separately, force word_err_count near max (CNT_W = 4 build) and inject 3 more errors.
  - Required: counters read 0 after the clear, and err_flag still pulses; the counter holds at 15 with no wrap.
- Async reset while locked:
  - Stimulus: assert reset mid-cycle while locked.
  - Required: locked and all counters go to 0 immediately, before the next clock edge; re-lock proceeds as in the seed-1 case.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Definitions shared by the 128-bit LFSR pattern generator and checker.
// Both ends call lfsr_next() so the polynomial is defined in exactly one place.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 128;

  // x^128 + x^126 + x^101 + x^99 + 1, Fibonacci form
  localparam int TAP_A = 127;
  localparam int TAP_B = 125;
  localparam int TAP_C = 100;
  localparam int TAP_D = 98;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lfsr_state_t;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/lfsr_checker_popcount128.sv
// Combinational population count of a WIDTH-bit vector; zero latency.
module popcount128 #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] vec,
  output logic [7:0]       count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + 8'(vec[i]);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// LFSR pattern checker: self-seeds from received words, locks, then counts word/bit errors.
// One-cycle registered latency from a valid word to all outputs; always accepts data.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH        = LFSR_WIDTH,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 8,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] word_err_count,
  output logic [CNT_W-1:0] bit_err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam int AW = ((CNT_W > 8) ? CNT_W : 8) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lfsr_state_t      state;
  logic [WIDTH-1:0] expected;
  logic [MW-1:0]    match_cnt;
  logic [UW-1:0]    miss_cnt;
  logic [WIDTH-1:0] diff;
  logic [7:0]       diff_bits;
  logic             mismatch;
  logic [AW-1:0]    bit_sum;

  assign diff     = data_in ^ expected;
  assign mismatch = (diff != '0);
  // One bit of headroom turns overflow of the running bit count into a saturate decision
  assign bit_sum  = AW'(bit_err_count) + AW'(diff_bits);

  popcount128 #(.WIDTH(WIDTH)) u_popcount (
    .vec   (diff),
    .count (diff_bits)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      err_flag  <= 1'b0;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      err_flag <= 1'b0;
      if (data_valid) begin
        if (state == SEARCH) begin
          // An all-zero word is the lockup state and can never seed a candidate
          if (expected != '0 && !mismatch) begin
            expected <= lfsr_next(expected);
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end else begin
            match_cnt <= '0;
            expected  <= (data_in == '0) ? '0 : lfsr_next(data_in);
          end
        end else if (mismatch) begin
          err_flag <= 1'b1;
          if (miss_cnt == UW'(UNLOCK_COUNT - 1)) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
          end else begin
            expected <= lfsr_next(expected);
            miss_cnt <= miss_cnt + UW'(1);
          end
        end else begin
          expected <= lfsr_next(expected);
          miss_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count     <= '0;
      word_err_count <= '0;
      bit_err_count  <= '0;
    end else if (clear_counts) begin
      word_count     <= '0;
      word_err_count <= '0;
      bit_err_count  <= '0;
    end else if (data_valid && state == LOCKED) begin
      if (word_count != CNT_MAX) word_count <= word_count + CNT_W'(1);
      if (mismatch) begin
        if (word_err_count != CNT_MAX) word_err_count <= word_err_count + CNT_W'(1);
        bit_err_count <= (bit_sum > AW'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
      end
    end
  end

endmodule
